// File: rtl/exec_mem_pkg.sv
// Shared encodings for exec_mem_unit: main-control ALU op classes, R-type funct
// values and the 4-bit ALU operation codes.
package exec_mem_pkg;

    typedef enum logic [1:0] {
        ALU_OP_MEM   = 2'b00,
        ALU_OP_BEQ   = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_RSVD  = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [3:0] OP_DEFAULT = OP_ADD;

endpackage

// File: rtl/exec_mem_unit_dmem_array.sv
// DEPTH x 32 data memory: asynchronous clear on reset, one synchronous write
// port and a combinational read port sharing the same word index.
module dmem_array #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory helper: ALU operation decode, branch pc_src select and the
// word-organised data memory. Define EXEC_MEM_SHIFT_EN to decode sll/srl.
module exec_mem_unit
    import exec_mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    output logic [3:0]  operation,
    input  logic        branch,
    input  logic        zero,
    output logic        pc_src,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] word_idx;
    logic          in_range;
    logic [31:0]   array_rdata;
    logic [1:0]    byte_offset_unused;

    always_comb begin
        operation = OP_DEFAULT;
        case (alu_op_e'(alu_op))
            ALU_OP_MEM:  operation = OP_ADD;
            ALU_OP_BEQ:  operation = OP_SUB;
            ALU_OP_RSVD: operation = OP_ADD;
            ALU_OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: operation = OP_ADD;
                    FUNCT_SUB: operation = OP_SUB;
                    FUNCT_AND: operation = OP_AND;
                    FUNCT_OR:  operation = OP_OR;
                    FUNCT_NOR: operation = OP_NOR;
                    FUNCT_SLT: operation = OP_SLT;
`ifdef EXEC_MEM_SHIFT_EN
                    FUNCT_SLL: operation = OP_SLL;
                    FUNCT_SRL: operation = OP_SRL;
`endif
                    default:   operation = OP_DEFAULT;
                endcase
            end
            default: operation = OP_DEFAULT;
        endcase
    end

    assign pc_src = branch & zero;

    // Byte offset is deliberately ignored: accesses are always word-aligned.
    assign byte_offset_unused = addr[1:0];
    assign word_idx           = addr[AW+1:2];
    assign in_range           = (addr[31:AW+2] == '0);

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_write & in_range),
        .idx   (word_idx),
        .wdata (wdata),
        .rdata (array_rdata)
    );

    assign rdata = (mem_read && in_range) ? array_rdata : 32'h0;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: directed steps plus random traffic
// compared against a behavioural model of decode, branch select and memory.
module tb_exec_mem_unit;

    localparam int DEPTH = 256;
    localparam longint MEM_BYTES = longint'(DEPTH) * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [3:0]  operation;
    logic        branch;
    logic        zero;
    logic        pc_src;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rdata;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [DEPTH];

    exec_mem_unit #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_op    (alu_op),
        .funct     (funct),
        .operation (operation),
        .branch    (branch),
        .zero      (zero),
        .pc_src    (pc_src),
        .addr      (addr),
        .wdata     (wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode from the instruction-set meaning of each op class.
    function automatic logic [3:0] ref_operation(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b01) return 4'b0110;
        if (op != 2'b10) return 4'b0010;
        if (f == 6'h20) return 4'b0010;
        if (f == 6'h22) return 4'b0110;
        if (f == 6'h24) return 4'b0000;
        if (f == 6'h25) return 4'b0001;
        if (f == 6'h27) return 4'b1100;
        if (f == 6'h2A) return 4'b0111;
`ifdef EXEC_MEM_SHIFT_EN
        if (f == 6'h00) return 4'b0011;
        if (f == 6'h02) return 4'b0100;
`endif
        return 4'b0010;
    endfunction

    function automatic logic [31:0] ref_rdata();
        if (!mem_read || !rst_n) return 32'h0;
        if (longint'(addr) >= MEM_BYTES) return 32'h0;
        return model_mem[addr / 4];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    // One clock: apply the store to the model, take the edge, settle.
    task automatic tick();
        if (rst_n && mem_write && longint'(addr) < MEM_BYTES)
            model_mem[addr / 4] = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic mem_drive(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
        addr = a; wdata = d; mem_read = rd; mem_write = wr;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; alu_op = 2'b00; funct = 6'h0; branch = 1'b0; zero = 1'b0;
        addr = 32'h0; wdata = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        mem_drive(32'h0, 32'h0, 1'b1, 1'b0);
        check("reset_rdata_0x0", rdata, 32'h0);
        mem_drive(32'h3FC, 32'h0, 1'b1, 1'b0);
        check("reset_rdata_0x3fc", rdata, 32'h0);
        alu_op = 2'b00; #1;
        check("reset_op_00", {28'h0, operation}, 32'h2);

        // Decode sweep
        alu_op = 2'b10;
        funct = 6'h20; #1; check("dec_add", {28'h0, operation}, 32'h2);
        funct = 6'h22; #1; check("dec_sub", {28'h0, operation}, 32'h6);
        funct = 6'h24; #1; check("dec_and", {28'h0, operation}, 32'h0);
        funct = 6'h25; #1; check("dec_or",  {28'h0, operation}, 32'h1);
        funct = 6'h27; #1; check("dec_nor", {28'h0, operation}, 32'hC);
        funct = 6'h2A; #1; check("dec_slt", {28'h0, operation}, 32'h7);
        funct = 6'h3F; #1; check("dec_dflt", {28'h0, operation}, 32'h2);
        alu_op = 2'b01; #1; check("dec_beq", {28'h0, operation}, 32'h6);
        alu_op = 2'b11; #1; check("dec_op11", {28'h0, operation}, 32'h2);

        // Shift option
        alu_op = 2'b10;
`ifdef EXEC_MEM_SHIFT_EN
        funct = 6'h00; #1; check("dec_sll", {28'h0, operation}, 32'h3);
        funct = 6'h02; #1; check("dec_srl", {28'h0, operation}, 32'h4);
`else
        funct = 6'h00; #1; check("dec_sll", {28'h0, operation}, 32'h2);
        funct = 6'h02; #1; check("dec_srl", {28'h0, operation}, 32'h2);
`endif

        // Random decode against the reference
        for (int i = 0; i < 60; i++) begin
            alu_op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) funct = 6'($urandom);
            else begin
                case ($urandom_range(0, 7))
                    0: funct = 6'h20; 1: funct = 6'h22; 2: funct = 6'h24; 3: funct = 6'h25;
                    4: funct = 6'h27; 5: funct = 6'h2A; 6: funct = 6'h00; default: funct = 6'h02;
                endcase
            end
            #1;
            check("dec_rand", {28'h0, operation}, {28'h0, ref_operation(alu_op, funct)});
        end

        // Branch AND
        for (int b = 0; b < 2; b++) begin
            for (int z = 0; z < 2; z++) begin
                branch = 1'(b); zero = 1'(z); #1;
                check("pc_src", {31'h0, pc_src}, (b == 1 && z == 1) ? 32'h1 : 32'h0);
            end
        end

        // Store / load
        mem_drive(32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
        tick();
        mem_drive(32'h10, 32'h0, 1'b1, 1'b0);
        check("load_0x10", rdata, 32'hDEADBEEF);
        mem_drive(32'h13, 32'h0, 1'b1, 1'b0);
        check("load_0x13", rdata, 32'hDEADBEEF);
        mem_drive(32'h10, 32'h0, 1'b0, 1'b0);
        check("load_noread", rdata, 32'h0);

        // Same-cycle read and write
        mem_drive(32'h20, 32'h1, 1'b0, 1'b1);
        tick();
        mem_drive(32'h20, 32'h2, 1'b1, 1'b1);
        check("rw_before_edge", rdata, 32'h1);
        tick();
        check("rw_after_edge", rdata, 32'h2);

        // Out of range
        mem_drive(32'(DEPTH * 4), 32'h5, 1'b0, 1'b1);
        tick();
        mem_drive(32'(DEPTH * 4), 32'h0, 1'b1, 1'b0);
        check("oor_read", rdata, 32'h0);
        mem_drive(32'h0, 32'h0, 1'b1, 1'b0);
        check("oor_no_alias", rdata, ref_rdata());

        // Random memory traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = 32'(DEPTH * 4) + ($urandom & 32'h0FFF_FFFF);
            else if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(0, 3));
            else a = ($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
            mem_drive(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("rand_pre", rdata, ref_rdata());
            tick();
            check("rand_post", rdata, ref_rdata());
        end

        // Reset mid-run, arriving during a store
        mem_drive(32'h10, 32'h12345678, 1'b0, 1'b1);
        tick();
        mem_drive(32'h10, 32'hCAFEF00D, 1'b1, 1'b1);
        check("pre_reset_load", rdata, 32'h12345678);
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("reset_async_clear", rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_drive(32'h10, 32'h0, 1'b1, 1'b0);
        check("reset_wins_store", rdata, 32'h0);
        mem_drive(32'h20, 32'h0, 1'b1, 1'b0);
        check("reset_clears_0x20", rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
